divider_seq65: RTL and testbench

// - Iterative restoring divider: the inverse operation to the in-order core's 65-bit carry-chain adder.
// - One quotient bit per cycle from a (WIDTH+1)-bit subtract: ~divisor with carry-in 1.
// - Sits beside the ALU in the execute stage.
// - Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/divider_seq65.sv | 145 ++++++++++++++
 tb/tb_divider_seq65.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq65.sv
// Iterative restoring divider: one quotient bit per cycle from a (WIDTH+1)-bit
// subtract, with sign fix-up for two's-complement operands and a divide-by-zero bypass.
module divider_seq65 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   sub_diff;
  logic             sub_carry;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             unused_diff_msb;

  // Magnitude of the most negative value is 2^(WIDTH-1), representable unsigned.
  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? (~dividend + WIDTH'(1)) : dividend;
    b_mag = b_neg ? (~divisor + WIDTH'(1)) : divisor;
  end

  // quo_q doubles as the dividend shift register: its MSB feeds the remainder
  // while each new quotient bit enters at the LSB.
  always_comb begin
    rem_sh                = {rem_q, quo_q[WIDTH-1]};
    {sub_carry, sub_diff} = {1'b0, rem_sh} + {1'b0, ~{1'b0, div_q}} + (WIDTH+2)'(1);
    rem_d                 = sub_carry ? sub_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_d                 = {quo_q[WIDTH-2:0], sub_carry};
    unused_diff_msb       = sub_diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (divisor == '0) begin
              dbz_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              dbz_q     <= 1'b0;
              rem_q     <= '0;
              quo_q     <= a_mag;
              div_q     <= b_mag;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt_q     <= CW'(WIDTH - 1);
              state_q   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          quotient_q  <= neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
          remainder_q <= neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq65.sv
// Scoreboard bench for divider_seq65: directed vectors plus random pairs
// checked against RISC-V DIV/DIVU/REM/REMU semantics.
module tb_divider_seq65;

  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        is_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  divider_seq65 #(.WIDTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   throttle  = 0;
  bit   rdy_force = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t golden(input logic [63:0] a, input logic [63:0] b, input logic sgn);
    exp_t   e;
    longint sx;
    longint sy;
    e.acc = 0;
    e.dbz = 1'b0;
    e.lat = 66;
    if (b == 64'd0) begin
      e.q = ONES; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (sgn) begin
      if (a == MIN && b == ONES) begin
        e.q = MIN; e.r = 64'd0;
      end else begin
        sx = longint'(a); sy = longint'(b);
        e.q = 64'(sx / sy);
        e.r = 64'(sx % sy);
      end
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                       input logic [63:0] eq, input logic [63:0] er, input logic edbz,
                       input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      return;
    end
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    @(posedge clk);
    #1;
    e.q = eq; e.r = er; e.dbz = edbz; e.acc = cyc; e.lat = edbz ? 1 : 66;
    if (push) sb.push_back(e);
    in_valid  = 1'b0;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic monitor();
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 0;
      end else if (out_valid) begin
        if (!seen && sb.size() > 0) begin
          seen = 1;
          chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
        end
        if (out_ready) begin
          seen = 0;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_result actual q=%h r=%h expected no result", quotient, remainder);
          end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #2;
      out_ready = throttle ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    exp_t        e;
    logic [63:0] a;
    logic [63:0] b;
    logic        sgn;
    int          n;

    reset = 1'b1; in_valid = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; out_ready = 1'b1;
    fork
      monitor();
      ready_drv();
      begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_remainder", remainder, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;

    issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 1);
    issue(-64'd100, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1);
    issue(64'd100, -64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1);
    issue(64'h2dab324f789f34ff, 64'd0, 1'b0, ONES, 64'h2dab324f789f34ff, 1'b1, 1);
    issue(64'h8000_0000_0000_0001, 64'd0, 1'b1, ONES, 64'h8000_0000_0000_0001, 1'b1, 1);
    issue(MIN, ONES, 1'b1, MIN, 64'd0, 1'b0, 1);
    issue(MIN, ONES, 1'b0, 64'd0, MIN, 1'b0, 1);
    issue(ONES, 64'd1, 1'b0, ONES, 64'd0, 1'b0, 1);
    issue(-64'd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0, 1);
    drain();

    // Back-pressure: result held, new requests ignored.
    rdy_force = 1'b0;
    issue(64'd100, -64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; dividend = 64'd55; divisor = 64'd5; is_signed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_quotient", quotient, 64'hFFFF_FFFF_FFFF_FFF2);
      chk("hold_remainder", remainder, 64'd2);
    end
    in_valid  = 1'b0;
    rdy_force = 1'b1;
    drain();
    repeat (80) @(negedge clk);

    // Abort mid-calculation.
    issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 0);
    repeat (29) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    issue(64'd9, 64'd3, 1'b0, 64'd3, 64'd0, 1'b0, 1);
    drain();

    throttle = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       b = 64'd0;
        1:       b = ONES;
        2, 3:    b = 64'($urandom_range(1, 20));
        4:       b = -64'($urandom_range(1, 20));
        5:       b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 15) == 0) a = MIN;
      e = golden(a, b, sgn);
      issue(a, b, sgn, e.q, e.r, e.dbz, 1);
    end
    drain();
    throttle = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
